// File: rtl/cycle_seq_pkg.sv
// cycle_seq_pkg: shared definitions for the instruction cycle sequencer.
//   state_t          - sequencer state encoding (also driven on the phase port)
//   OP_LW / OP_SW    - opcodes that need a data memory phase
//   TIMEOUT_DEFAULT  - default bound on memory ack wait, in cycles
//   is_mem_op()      - true for opcodes that visit the MEM state
package cycle_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4
  } state_t;

  localparam logic [5:0] OP_LW = 6'b111100;
  localparam logic [5:0] OP_SW = 6'b001100;

  localparam int TIMEOUT_DEFAULT = 255;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/cycle_seq_wait_timer.sv
// cycle_seq_wait_timer: counts cycles spent waiting for a memory ack.
//   clk, rst  - clock and asynchronous active-low reset
//   clear     - restart the count (entering a wait state); wins over count
//   count     - this cycle ended without an ack
//   expire    - this unacknowledged cycle is the LIMIT-th one; the caller
//               aborts on it. Because count is already qualified by the
//               absence of an ack, an ack on that same cycle always wins.
module cycle_seq_wait_timer
  import cycle_seq_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  // wait counter: cleared on entry to a wait state, advanced per idle cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign expire = count && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/cycle_seq.sv
// cycle_seq: fetch/decode/execute/memory sequencer for a simple CPU.
//   clk, rst            - clock, asynchronous active-low reset
//   run, step           - free-run level / single-instruction pulse
//   opcode              - instruction register opcode (valid from DECODE)
//   imem_req/imem_ack   - instruction fetch handshake
//   ir_load             - load instruction register (fetch ack cycle)
//   dmem_req/dmem_we    - data access handshake for LW/SW, dmem_ack returns
//   commit              - one-cycle pulse retiring the current instruction
//   phase, busy         - state encoding / not idle
//   bus_err             - sticky memory-ack timeout flag
//   retired             - wrapping count of committed instructions
// Request, commit and phase outputs are decoded straight from the state
// register (plus the ack for the same-cycle pulses) so that reset removes
// them immediately and acks are honoured in the cycle they arrive.
module cycle_seq
  import cycle_seq_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic [5:0]       opcode,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_load,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             commit,
  output logic [2:0]       phase,
  output logic             busy,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired
);

  state_t state;
  state_t next_state;
  logic   step_flag;
  logic   wait_clear;
  logic   wait_count;
  logic   wait_expire;

  // output decode; acks are only looked at while their request is up
  always_comb begin
    imem_req   = (state == ST_FETCH);
    ir_load    = imem_req && imem_ack;
    dmem_req   = (state == ST_MEM);
    dmem_we    = dmem_req && (opcode == OP_SW);
    commit     = ((state == ST_EXEC) && !is_mem_op(opcode)) || (dmem_req && dmem_ack);
    phase      = state;
    busy       = (state != ST_IDLE);
    wait_count = (imem_req && !imem_ack) || (dmem_req && !dmem_ack);
  end

  // next-state logic; after a commit, run alone decides whether to continue
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (run || step) next_state = ST_FETCH;
        else             next_state = ST_IDLE;
      end
      ST_FETCH: begin
        if (imem_ack)         next_state = ST_DECODE;
        else if (wait_expire) next_state = ST_IDLE;
        else                  next_state = ST_FETCH;
      end
      ST_DECODE: begin
        next_state = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_mem_op(opcode)) next_state = ST_MEM;
        else if (run)          next_state = ST_FETCH;
        else                   next_state = ST_IDLE;
      end
      ST_MEM: begin
        if (dmem_ack)         next_state = run ? ST_FETCH : ST_IDLE;
        else if (wait_expire) next_state = ST_IDLE;
        else                  next_state = ST_MEM;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // restart the wait count only when a wait state is newly entered
  always_comb begin
    wait_clear = ((next_state == ST_FETCH) && (state != ST_FETCH)) ||
                 ((next_state == ST_MEM)   && (state != ST_MEM));
  end

  cycle_seq_wait_timer #(
    .LIMIT (TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (wait_clear),
    .count  (wait_count),
    .expire (wait_expire)
  );

  // sequencer state, sticky error, retire counter and single-step marker
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      bus_err   <= 1'b0;
      retired   <= '0;
      step_flag <= 1'b0;
    end else begin
      state   <= next_state;
      bus_err <= bus_err | wait_expire;
      if (commit) retired <= retired + CNT_W'(1);
      else        retired <= retired;
      // step only counts when taken from IDLE; the instruction ending
      // (commit or abort) consumes it
      if ((state == ST_IDLE) && step)              step_flag <= 1'b1;
      else if (step_flag && (commit || wait_expire)) step_flag <= 1'b0;
      else                                          step_flag <= step_flag;
    end
  end

endmodule

// File: doc/cycle_seq.md
CYCLE_SEQ -- requirements
Module: cycle_seq

Interface
REQ-001 Parameter TIMEOUT, default 255, max cycles waited for any memory ack before abort.
REQ-002 Parameter CNT_W, default 16, width of retired-instruction counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-005 run  input  1  level; 1 = free-run instructions.
REQ-006 step  input  1  one-cycle pulse; executes exactly one instruction from IDLE.
REQ-007 opcode  input  6  current instruction register opcode (valid from DECODE onward).
REQ-008 imem_ack  input  1  instruction memory ack; meaningful only while imem_req=1.
REQ-009 dmem_ack  input  1  data memory ack; meaningful only while dmem_req=1.
REQ-010 imem_req  output  1  instruction fetch request.
REQ-011 ir_load  output  1  one-cycle pulse loading instruction register.
REQ-012 dmem_req  output  1  data memory request (LW/SW).
REQ-013 dmem_we  output  1  1 = data write (SW); valid only with dmem_req.
REQ-014 commit  output  1  one-cycle pulse gating control-unit pc_en, reg_write_en, mem_write_en.
REQ-015 phase  output  3  current state encoding.
REQ-016 busy  output  1  1 in any state except IDLE.
REQ-017 bus_err  output  1  sticky timeout flag.
REQ-018 retired  output  CNT_W  count of committed instructions.

Function
REQ-019 States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4; phase SHALL equal the encoding.
REQ-020 IDLE -> FETCH when run=1 or step=1; step latched into a one-shot flag; else stay.
REQ-021 FETCH: imem_req=1 every cycle held; on imem_ack=1 -> DECODE with ir_load=1 in that same cycle.
REQ-022 DECODE: single cycle, no outputs asserted -> EXEC.
REQ-023 EXEC: opcode 111100 (LW) or 001100 (SW) -> MEM; all other opcodes -> commit=1 this cycle, then next state per REQ-026.
REQ-024 MEM: dmem_req=1 held, dmem_we=1 iff opcode=001100; on dmem_ack=1 -> commit=1 this cycle, then per REQ-026.
REQ-025 Unmapped opcodes SHALL still commit (control unit handles decode); sequencer never traps.
REQ-026 After commit: run=1 -> FETCH; else -> IDLE; step one-shot cleared on commit.
REQ-027 Latency without waits: 3 cycles per non-memory instruction, 4 per LW/SW (FETCH ack, DECODE, EXEC, MEM ack).
REQ-028 Wait counter cleared on entry to FETCH/MEM, increments each cycle without ack; reaching TIMEOUT -> bus_err=1, no commit, drop req, -> IDLE.
REQ-029 Ack arriving in the same cycle the counter reaches TIMEOUT SHALL win (normal completion, no bus_err).
REQ-030 Acks when the corresponding req=0 SHALL be ignored.
REQ-031 run deasserted mid-instruction: current instruction completes; return to IDLE after commit.
REQ-032 step while not IDLE ignored.
REQ-033 retired increments by 1 on each commit, wraps from all-ones to 0.
REQ-034 bus_err cleared only by reset.

Reset
REQ-035 rst=0 SHALL immediately force IDLE, imem_req=dmem_req=dmem_we=ir_load=commit=0, busy=0, bus_err=0, retired=0, wait counter=0, step flag=0.
REQ-036 Reset mid-MEM SHALL drop dmem_req asynchronously with no commit.
REQ-037 First FETCH no earlier than first rising edge after rst=1 with run or step.

Structure
REQ-038 Shared package SHALL hold state enum, LW/SW opcode constants, default TIMEOUT.
REQ-039 One sub-module natural: wait_timer (load/clear, count, expire).

Verification
REQ-040 run=1, opcode=110100, acks immediate -> commit every 3rd cycle, retired=3 after 9 cycles.
REQ-041 opcode=111100, dmem_ack delayed 5 cycles -> dmem_req high 6 cycles, dmem_we=0, single commit on ack cycle.
REQ-042 opcode=001100 -> dmem_we=1 with dmem_req; commit exactly once.
REQ-043 TIMEOUT=4, imem_ack never -> bus_err=1 after 4 FETCH cycles, phase=0, retired unchanged.
REQ-044 run=0, step pulse -> exactly one commit then phase=0; second step mid-instruction ignored.
REQ-045 rst=0 during MEM -> dmem_req=0 same cycle, retired=0, phase=0.
